// File: rtl/pmpd_pkg.sv
// Shared types and constants for the pedal-misapplication actuation stage.
package pmpd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_CUT     = 3'd2,
      ST_RAMP    = 3'd3,
      ST_HOLD    = 3'd4,
      ST_RELEASE = 3'd5
   } state_e;

   localparam logic [7:0] DUTY_MAX = 8'd255;

   localparam int RAMP_STEP_DEF    = 16;
   localparam int RELEASE_STEP_DEF = 8;
   localparam int HOLD_TICKS_DEF   = 30;
   localparam int ARM_TICKS_DEF    = 2;

   // 9-bit add so the carry out tells us to clamp at full duty
   function automatic logic [7:0] duty_up(input logic [7:0] duty, input logic [7:0] step);
      logic [8:0] sum;
      sum = {1'b0, duty} + {1'b0, step};
      return sum[8] ? DUTY_MAX : sum[7:0];
   endfunction

   // borrow out of the 9-bit subtract means we would go below zero
   function automatic logic [7:0] duty_down(input logic [7:0] duty, input logic [7:0] step);
      logic [8:0] diff;
      diff = {1'b0, duty} - {1'b0, step};
      return diff[8] ? 8'd0 : diff[7:0];
   endfunction

endpackage

// File: rtl/pmpd_actuator_pwm_gen8.sv
// 8-bit PWM: free-running counter with a registered compare against duty.
module pwm_gen8
   import pmpd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] duty,
   output logic       pwm
);

   logic [7:0] cnt_q, cnt_d;
   logic       pwm_q, pwm_d;

   // counter wraps naturally; compare is strict so 255 leaves one low slot
   always_comb begin
      cnt_d = cnt_q + 8'd1;
      pwm_d = (cnt_q < duty);
   end

   // counter and compare registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/pmpd_actuator.sv
// Actuation sequencer: throttle cut, ramped brake assist, timed hold,
// driver-acknowledged release and buzzer.
//
// state   | meaning
// IDLE    | no action, all outputs low
// ARM     | drive seen, counting consecutive drive ticks
// CUT     | throttle cut, brake duty still zero
// RAMP    | brake duty rising by RAMP_STEP per tick
// HOLD    | full brake duty for HOLD_TICKS ticks
// RELEASE | brake duty falling by RELEASE_STEP per tick
module pmpd_actuator
   import pmpd_pkg::*;
#(
   parameter int RAMP_STEP    = RAMP_STEP_DEF,
   parameter int RELEASE_STEP = RELEASE_STEP_DEF,
   parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
   parameter int ARM_TICKS    = ARM_TICKS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_10hz,
   input  logic       drive,
   input  logic       release_req,
   output logic       throttle_cut,
   output logic       brake_pwm,
   output logic [7:0] brake_duty,
   output logic       buzzer,
   output logic       active
);

   localparam logic [7:0]  RAMP_STEP_B = 8'(RAMP_STEP);
   localparam logic [7:0]  REL_STEP_B  = 8'(RELEASE_STEP);
   localparam logic [7:0]  ARM_MAX     = 8'(ARM_TICKS);
   localparam logic [15:0] HOLD_LAST   = 16'(HOLD_TICKS - 1);

   state_e      state_q, state_d;
   logic [7:0]  arm_cnt_q, arm_cnt_d;
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic [7:0]  duty_q, duty_d;
   logic        buzzer_q, buzzer_d;
   logic        throttle_cut_q, throttle_cut_d;
   logic        active_q, active_d;
   logic        rel_s1_q, rel_s1_d;
   logic        rel_s2_q, rel_s2_d;

   // next-state, counters and registered outputs; everything moves only on a tick
   always_comb begin
      state_d    = state_q;
      arm_cnt_d  = arm_cnt_q;
      hold_cnt_d = hold_cnt_q;
      duty_d     = duty_q;
      buzzer_d   = buzzer_q;
      rel_s1_d   = release_req;
      rel_s2_d   = rel_s1_q;

      if (tick_10hz) begin
         case (state_q)
            ST_IDLE: begin
               if (drive) begin
                  state_d   = ST_ARM;
                  arm_cnt_d = 8'd1;
               end
            end
            ST_ARM: begin
               if (!drive) begin
                  state_d   = ST_IDLE;
                  arm_cnt_d = 8'd0;
               end else if (arm_cnt_q >= ARM_MAX) begin
                  state_d   = ST_CUT;
                  arm_cnt_d = 8'd0;
               end else begin
                  arm_cnt_d = arm_cnt_q + 8'd1;
               end
            end
            ST_CUT: begin
               state_d = ST_RAMP;
               duty_d  = duty_up(duty_q, RAMP_STEP_B);
            end
            ST_RAMP: begin
               if (duty_q == DUTY_MAX) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = 16'd0;
               end else begin
                  duty_d = duty_up(duty_q, RAMP_STEP_B);
               end
            end
            ST_HOLD: begin
               duty_d = DUTY_MAX;
               // the driver can only cut the hold short once the detector lets go
               if (rel_s2_q && !drive) begin
                  state_d = ST_RELEASE;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  if (drive) hold_cnt_d = 16'd0;
                  else       state_d    = ST_RELEASE;
               end else begin
                  hold_cnt_d = hold_cnt_q + 16'd1;
               end
            end
            ST_RELEASE: begin
               // re-escalation wins over the decrement
               if (drive) begin
                  state_d = ST_RAMP;
                  duty_d  = duty_up(duty_q, RAMP_STEP_B);
               end else if (duty_q == 8'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  duty_d = duty_down(duty_q, REL_STEP_B);
               end
            end
            default: state_d = ST_IDLE;
         endcase
         buzzer_d = (state_d == ST_IDLE) ? 1'b0 : ~buzzer_q;
      end

      active_d       = (state_d != ST_IDLE);
      throttle_cut_d = (state_d == ST_CUT) || (state_d == ST_RAMP) ||
                       (state_d == ST_HOLD) || (state_d == ST_RELEASE);
   end

   // state, counters, synchronizer and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         arm_cnt_q      <= 8'd0;
         hold_cnt_q     <= 16'd0;
         duty_q         <= 8'd0;
         buzzer_q       <= 1'b0;
         throttle_cut_q <= 1'b0;
         active_q       <= 1'b0;
         rel_s1_q       <= 1'b0;
         rel_s2_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         arm_cnt_q      <= arm_cnt_d;
         hold_cnt_q     <= hold_cnt_d;
         duty_q         <= duty_d;
         buzzer_q       <= buzzer_d;
         throttle_cut_q <= throttle_cut_d;
         active_q       <= active_d;
         rel_s1_q       <= rel_s1_d;
         rel_s2_q       <= rel_s2_d;
      end
   end

   pwm_gen8 u_pwm (
      .clk   (clk),
      .rst_n (rst_n),
      .duty  (duty_q),
      .pwm   (brake_pwm)
   );

   assign throttle_cut = throttle_cut_q;
   assign brake_duty   = duty_q;
   assign buzzer       = buzzer_q;
   assign active       = active_q;

endmodule

// File: tb/tb_pmpd_actuator.sv
// Bench for pmpd_actuator: table vectors, hand sequences and random ticks
// checked against a tick-level reference model.
module tb_pmpd_actuator;

   localparam int RSTEP = 16;
   localparam int DSTEP = 8;
   localparam int HOLDT = 30;
   localparam int ARMT  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_10hz;
   logic       drive;
   logic       release_req;
   logic       throttle_cut;
   logic       brake_pwm;
   logic [7:0] brake_duty;
   logic       buzzer;
   logic       active;

   pmpd_actuator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_10hz    (tick_10hz),
      .drive        (drive),
      .release_req  (release_req),
      .throttle_cut (throttle_cut),
      .brake_pwm    (brake_pwm),
      .brake_duty   (brake_duty),
      .buzzer       (buzzer),
      .active       (active)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference model: phase names are bench-local
   localparam int P_IDLE = 0, P_ARM = 1, P_CUT = 2, P_RAMP = 3, P_HOLD = 4, P_REL = 5;
   int m_phase, m_arm, m_hold, m_duty;
   bit m_buz;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction
   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_arm = 0; m_hold = 0; m_duty = 0; m_buz = 0;
   endtask

   task automatic model_tick(input bit drv, input bit rel);
      int nxt;
      nxt = m_phase;
      case (m_phase)
         P_IDLE: if (drv) begin nxt = P_ARM; m_arm = 1; end
         P_ARM: begin
            if (!drv) begin nxt = P_IDLE; m_arm = 0; end
            else if (m_arm == ARMT) nxt = P_CUT;
            else m_arm = m_arm + 1;
         end
         P_CUT: begin nxt = P_RAMP; m_duty = imin(m_duty + RSTEP, 255); end
         P_RAMP: begin
            if (m_duty == 255) begin nxt = P_HOLD; m_hold = 0; end
            else m_duty = imin(m_duty + RSTEP, 255);
         end
         P_HOLD: begin
            if (rel && !drv) nxt = P_REL;
            else if (m_hold == HOLDT - 1) begin
               if (drv) m_hold = 0; else nxt = P_REL;
            end else m_hold = m_hold + 1;
         end
         default: begin
            if (drv) begin nxt = P_RAMP; m_duty = imin(m_duty + RSTEP, 255); end
            else if (m_duty == 0) nxt = P_IDLE;
            else m_duty = imax(m_duty - DSTEP, 0);
         end
      endcase
      m_phase = nxt;
      m_buz = (nxt == P_IDLE) ? 1'b0 : ~m_buz;
   endtask

   // one tick with optional 3-clk release pulse timed to land on that tick
   task automatic do_tick(input bit drv, input bit rel, input int gap);
      repeat (gap) @(negedge clk);
      drive = drv;
      if (rel) begin
         release_req = 1'b1;
         repeat (3) @(negedge clk);
         release_req = 1'b0;
      end
      tick_10hz = 1'b1;
      @(negedge clk);
      tick_10hz = 1'b0;
      model_tick(drv, rel);
      check("mdl_active", 16'(active), 16'(m_phase != P_IDLE));
      check("mdl_cut", 16'(throttle_cut), 16'(m_phase >= P_CUT));
      check("mdl_duty", 16'(brake_duty), 16'(m_duty));
      check("mdl_buzzer", 16'(buzzer), 16'(m_buz));
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; drive = 1'b0; release_req = 1'b0; tick_10hz = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {11'd0, throttle_cut, brake_pwm, buzzer, active, |brake_duty}, 16'd0);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic pwm_count(input string name, input int exp_high);
      int n;
      n = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (brake_pwm === 1'b1) n++;
      end
      check(name, 16'(n), 16'(exp_high));
   endtask

   typedef struct {
      bit         drv;
      bit         rel;
      bit         cut;
      bit         act;
      bit         buz;
      logic [7:0] duty;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int  exp_d;
      bit  drv_r;
      rst_n = 1'b0; drive = 1'b0; release_req = 1'b0; tick_10hz = 1'b0;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd16};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd32};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd48};

      // arming, abort back to IDLE, re-arm into the ramp
      do_reset();
      pwm_count("pwm_idle", 0);
      for (int i = 0; i < 8; i++) begin
         do_tick(tbl[i].drv, tbl[i].rel, 0);
         check("tbl_cut", 16'(throttle_cut), 16'(tbl[i].cut));
         check("tbl_active", 16'(active), 16'(tbl[i].act));
         check("tbl_buzzer", 16'(buzzer), 16'(tbl[i].buz));
         check("tbl_duty", 16'(brake_duty), 16'(tbl[i].duty));
      end
      pwm_count("pwm_48", 48);

      // full sequence with sustained drive, then timed release to IDLE
      do_reset();
      for (int t = 1; t <= 60; t++) begin
         do_tick(1'b1, 1'b0, 0);
         exp_d = (t < 4) ? 0 : imin(RSTEP * (t - 3), 255);
         check("seq_cut", 16'(throttle_cut), 16'(t >= 3));
         check("seq_duty", 16'(brake_duty), 16'(exp_d));
      end
      pwm_count("pwm_full", 255);
      for (int t = 61; t <= 113; t++) begin
         do_tick(1'b0, 1'b0, 0);
         exp_d = (t <= 80) ? 255 : imax(255 - DSTEP * (t - 80), 0);
         check("rel_duty", 16'(brake_duty), 16'(exp_d));
         check("rel_cut", 16'(throttle_cut), 16'(t < 113));
         check("rel_active", 16'(active), 16'(t < 113));
      end

      // early release: ignored with drive high, honoured with drive low
      do_reset();
      for (int t = 1; t <= 20; t++) do_tick(1'b1, 1'b0, 0);
      do_tick(1'b1, 1'b1, 0);
      do_tick(1'b0, 1'b0, 0);
      check("early_ignored", 16'(brake_duty), 16'd255);
      do_tick(1'b0, 1'b1, 0);
      do_tick(1'b0, 1'b0, 1);
      check("early_release", 16'(brake_duty), 16'd247);
      repeat (5) do_tick(1'b0, 1'b0, 0);
      check("pre_escalate", 16'(brake_duty), 16'd207);
      do_tick(1'b1, 1'b0, 0);
      check("escalate_duty", 16'(brake_duty), 16'd223);
      do_tick(1'b1, 1'b0, 0);
      do_tick(1'b1, 1'b0, 0);
      check("escalate_sat", 16'(brake_duty), 16'd255);
      do_tick(1'b1, 1'b0, 0);
      check("escalate_hold", 16'(brake_duty), 16'd255);

      // async reset in the middle of the ramp
      do_reset();
      for (int t = 1; t <= 11; t++) do_tick(1'b1, 1'b0, 0);
      check("ramp_128", 16'(brake_duty), 16'd128);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst", {11'd0, throttle_cut, brake_pwm, buzzer, active, |brake_duty}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive = 1'b0;
      do_tick(1'b0, 1'b0, 0);
      pwm_count("pwm_after_rst", 0);

      // random ticks against the model
      do_reset();
      drv_r = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0) drv_r = ~drv_r;
         do_tick(drv_r, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
